// File: rtl/sample_stream_buffer_pkg.sv
// Shared types and helpers for the FIR output sample stream buffer.
// Provides the sample word type and the valid/ready beat helper.
package Stream_p;

   localparam int OUT_WIDTH = 12;

   typedef logic [OUT_WIDTH-1:0] sample_t;

   // A transfer completes on any cycle where both sides agree.
   function automatic logic beat(input logic valid, input logic ready);
      return valid && ready;
   endfunction

endpackage

// File: rtl/sample_stream_buffer_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module sample_fifo_ram #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sample_stream_buffer.sv
// Captures FIR output samples after warm-up, queues them in a FWFT FIFO.
// Ports: clk/rst, in_sample/in_strobe/in_valid, out_* stream, level, overflow, drop_count.
module sample_stream_buffer
   import Stream_p::*;
#(
   parameter int WIDTH  = OUT_WIDTH,
   parameter int DEPTH  = 16,
   parameter int SKIP   = 2,
   parameter int DROP_W = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in_sample,
   input  logic              in_strobe,
   input  logic              in_valid,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LW-1:0]     level,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);

   localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

   logic [SKW-1:0]    skip_q, skip_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic accept, full, rd, wr, drop;

   assign out_valid = (level_q != '0);
   assign full      = (level_q == LW'(DEPTH));
   assign rd        = beat(out_valid, out_ready);
   assign accept    = in_strobe && in_valid && (skip_q == SKW'(SKIP));
   // A full FIFO still takes the sample if a slot frees this cycle.
   assign wr        = accept && (!full || rd);
   assign drop      = accept && !wr;

   always_comb begin
      skip_d   = skip_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;

      // Warm-up gate re-arms whenever the filter output goes invalid.
      if (!in_valid)
         skip_d = '0;
      else if (in_strobe && (skip_q < SKW'(SKIP)))
         skip_d = skip_q + SKW'(1);

      if (wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd) rd_ptr_d = rd_ptr_q + AW'(1);

      unique case ({wr, rd})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != {DROP_W{1'b1}})
            drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skip_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         skip_q   <= skip_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Reset gating of wr keeps a strobe in the reset cycle out of memory
   // semantically; the pointer reset makes any stray write unreachable.
   sample_fifo_ram #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr && !rst),
      .waddr(wr_ptr_q),
      .wdata(in_sample),
      .raddr(rd_ptr_q),
      .rdata(out_data)
   );

   assign level      = level_q;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Scoreboard bench for sample_stream_buffer with directed vectors.
// Stimulus pushes expected samples; a negedge monitor pops and compares.
module tb_sample_stream_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] in_sample;
   logic        in_strobe;
   logic        in_valid;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  level;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   sample_stream_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .in_sample (in_sample),
      .in_strobe (in_strobe),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [11:0] s, input bit push);
      in_sample = s;
      in_strobe = 1'b1;
      if (push) exp_q.push_back(s);
      step();
      in_strobe = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((out_valid || level != 0) && n < 64) begin
         step();
         n++;
      end
      chk({name, "_drain_timeout"}, 32'(n < 64), 32'(1));
      chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
   endtask

   // Monitor: pops on every beat, and checks hold stability under back-pressure.
   logic        hold_p = 1'b0;
   logic [11:0] hold_d = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (hold_p) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_data", 32'(out_data), 32'(hold_d));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h expected none", out_data);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
      end
      hold_p = !rst && out_valid && !out_ready;
      hold_d = out_data;
   end

   initial begin
      rst       = 1'b1;
      in_sample = '0;
      in_strobe = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      chk("rst_drop", 32'(drop_count), 32'(0));
      rst = 1'b0;

      // 1: warm-up skip, 1-cycle latency
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      strobe(12'h800, 0);
      chk("t1_skip0", 32'(out_valid), 32'(0));
      strobe(12'h801, 0);
      chk("t1_skip1", 32'(out_valid), 32'(0));
      strobe(12'h802, 1);
      chk("t1_lat_v", 32'(out_valid), 32'(1));
      chk("t1_lat_d", 32'(out_data), 32'h802);
      step();
      strobe(12'h803, 1);
      chk("t1_lat_v2", 32'(out_valid), 32'(1));
      chk("t1_lat_d2", 32'(out_data), 32'h803);
      step();
      chk("t1_level", 32'(level), 32'(0));
      chk("t1_drop", 32'(drop_count), 32'(0));

      // 2: fill to full, one overflow
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) strobe(12'(12'h100 + i), 1);
      chk("t2_full", 32'(level), 32'(16));
      chk("t2_ovf0", 32'(overflow), 32'(0));
      strobe(12'h1FF, 0);
      chk("t2_level", 32'(level), 32'(16));
      chk("t2_ovf1", 32'(overflow), 32'(1));
      chk("t2_drop1", 32'(drop_count), 32'(1));

      // 3: read and write together at full
      out_ready = 1'b1;
      strobe(12'h2AA, 1);
      chk("t3_level", 32'(level), 32'(16));
      chk("t3_drop", 32'(drop_count), 32'(1));
      drain("t3");

      // 4: random back-pressure, one sample every 6 cycles
      for (int i = 0; i < 200; i++) begin
         for (int c = 0; c < 6; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (c == 0) strobe(12'((i * 37 + 5) & 12'hFFF), 1);
            else step();
         end
      end
      drain("t4");
      chk("t4_drop", 32'(drop_count), 32'(1));

      // 5: in_valid drop and restart
      out_ready = 1'b0;
      strobe(12'hA01, 1);
      strobe(12'hA02, 1);
      strobe(12'hA03, 1);
      chk("t5_level3", 32'(level), 32'(3));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) strobe(12'hBAD, 0);
      chk("t5_drained", 32'(level), 32'(0));
      in_valid = 1'b1;
      strobe(12'hC01, 0);
      chk("t5_skip0", 32'(out_valid), 32'(0));
      strobe(12'hC02, 0);
      chk("t5_skip1", 32'(out_valid), 32'(0));
      strobe(12'hC03, 1);
      chk("t5_acc_v", 32'(out_valid), 32'(1));
      chk("t5_acc_d", 32'(out_data), 32'hC03);
      step();
      chk("t5_queue", 32'(exp_q.size()), 32'(0));

      // 6a: reset mid-stream, strobe in the reset cycle ignored
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) strobe(12'(12'h300 + i), 1);
      chk("t6_level5", 32'(level), 32'(5));
      exp_q.delete();
      rst = 1'b1;
      strobe(12'hEEE, 0);
      rst = 1'b0;
      chk("t6_rst_v", 32'(out_valid), 32'(0));
      chk("t6_rst_lvl", 32'(level), 32'(0));
      chk("t6_rst_ovf", 32'(overflow), 32'(0));
      chk("t6_rst_drop", 32'(drop_count), 32'(0));

      // 6b: saturation of drop_count
      strobe(12'h000, 0);
      strobe(12'h001, 0);
      chk("t6_skip", 32'(level), 32'(0));
      for (int i = 0; i < 16; i++) strobe(12'(12'h400 + i), 1);
      chk("t6_full", 32'(level), 32'(16));
      for (int i = 0; i < 254; i++) strobe(12'h5A5, 0);
      chk("t6_drop254", 32'(drop_count), 32'(254));
      for (int i = 0; i < 46; i++) strobe(12'h5A5, 0);
      chk("t6_sat", 32'(drop_count), 32'(255));
      chk("t6_ovf", 32'(overflow), 32'(1));
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
